// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, per-key debounce counter,
// registered level/press/release outputs and optional typematic press strobes.
module key_debounce #(
  parameter int N_KEYS        = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = 250000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_raw,
  output logic [N_KEYS-1:0] keys_level,
  output logic [N_KEYS-1:0] keys_press,
  output logic [N_KEYS-1:0] keys_release
);

  localparam int CW   = $clog2(DB_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [N_KEYS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [N_KEYS-1:0] s1, s2, sync;
  logic [N_KEYS-1:0] accept;
  logic [N_KEYS-1:0] rep_fire;
  logic [CW-1:0]     cnt [N_KEYS];

  // Synchroniser idles at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= IDLE_RAW;
      s2 <= IDLE_RAW;
    end else begin
      s1 <= keys_raw;
      s2 <= s1;
    end
  end

  always_comb begin
    sync = (ACTIVE_LOW != 0) ? ~s2 : s2;
  end

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      accept[i] = (sync[i] != keys_level[i]) && (cnt[i] == CW'(DB_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
      keys_level   <= '0;
      keys_press   <= '0;
      keys_release <= '0;
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if ((sync[i] == keys_level[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      keys_level   <= (keys_level & ~accept) | (sync & accept);
      keys_press   <= (accept & sync) | rep_fire;
      keys_release <= accept & ~sync;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rep
      typedef enum logic {WAIT_FIRST, REPEATING} rep_state_t;

      rep_state_t    state    [N_KEYS];
      rep_state_t    state_nx [N_KEYS];
      logic [RW-1:0] rcnt     [N_KEYS];
      logic [RW-1:0] rcnt_nx  [N_KEYS];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < N_KEYS; i++) begin
            state[i] <= WAIT_FIRST;
            rcnt[i]  <= '0;
          end
        end else begin
          for (int unsigned i = 0; i < N_KEYS; i++) begin
            state[i] <= state_nx[i];
            rcnt[i]  <= rcnt_nx[i];
          end
        end
      end

      // Any accepted transition (press or release) restarts the delay phase.
      always_comb begin
        for (int unsigned i = 0; i < N_KEYS; i++) begin
          state_nx[i] = state[i];
          rcnt_nx[i]  = rcnt[i];
          if (accept[i]) begin
            state_nx[i] = WAIT_FIRST;
            rcnt_nx[i]  = '0;
          end else if (keys_level[i]) begin
            if (rep_fire[i]) begin
              state_nx[i] = REPEATING;
              rcnt_nx[i]  = '0;
            end else begin
              rcnt_nx[i] = rcnt[i] + 1'b1;
            end
          end
        end
      end

      always_comb begin
        rep_fire = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
          if (keys_level[i] && !accept[i]) begin
            if (state[i] == WAIT_FIRST) begin
              rep_fire[i] = (rcnt[i] == RW'(REPEAT_DELAY - 1));
            end else begin
              rep_fire[i] = (rcnt[i] == RW'(REPEAT_PERIOD - 1));
            end
          end
        end
      end
    end else begin : g_norep
      always_comb begin
        rep_fire = '0;
      end
    end
  endgenerate

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream input-conditioning stage for the 8bitworkshop game wrappers.
- Takes raw, asynchronous board push-buttons and delivers clean, synchronised, polarity-normalised key levels, ready to drive the left/right/up/down inputs of a game core.
- Also produces single-cycle press/release strobes and optional typematic (auto-repeat) press strobes for menu-style cores.
- Runs in the same clock domain as the game core it feeds (the divided pixel clock or the board clock).

Parameters:
- N_KEYS, 4, number of independent key channels.
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed.
- DB_CYCLES, 250000, consecutive clk cycles a new synchronised value must hold before it is accepted; legal range ≥1.
- REPEAT_EN, 1, 1 = enable auto-repeat strobes on keys_press; 0 = one strobe per physical press.
- REPEAT_DELAY, 12500000, cycles from accepted press to first repeat strobe; must be ≥1.
- REPEAT_PERIOD, 2500000, cycles between subsequent repeat strobes; must be ≥1.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high reset.
- keys_raw, input, N_KEYS, raw button pins, asynchronous to clk.
- keys_level, output, N_KEYS, debounced key state, 1 = pressed.
- keys_press, output, N_KEYS, one-cycle strobe on accepted press and on each auto-repeat.
- keys_release, output, N_KEYS, one-cycle strobe on accepted release.

Behaviour:
- Interface: reset is reset, asynchronous, active-high; clock is clk. All state is in the clk domain.
- Outputs are registered. All outputs are 0 during and after reset.
- **Synchroniser.** Two flops per key, each reset to the raw inactive level (all 1s if ACTIVE_LOW, else 0s), so no false press is generated out of reset. The second flop output is inverted when ACTIVE_LOW, giving sync[i] where 1 = pressed.
- **Debounce, per key, fully independent.**
  - Counter cnt[i], width $clog2(DB_CYCLES+1), reset 0.
  - Each edge with sync[i] == keys_level[i]: cnt <= 0.
  - Each edge with sync[i] != keys_level[i] and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - Edge with sync[i] != keys_level[i] and cnt == DB_CYCLES-1: keys_level[i] <= sync[i], cnt <= 0.
  - Any bounce back to the old level before acceptance clears cnt. Glitches shorter than DB_CYCLES cycles never reach keys_level.
- **Latency.** A raw change that is stable before clk edge E appears on keys_level at edge E+1+DB_CYCLES (2 sync edges, counting overlapped). With DB_CYCLES=1 the latency is exactly the synchroniser delay plus one.
- **Strobes.**
  - keys_press[i] is high for exactly the cycle in which keys_level[i] first reads 1.
  - keys_release[i] is high for exactly the cycle in which keys_level[i] first reads 0.
  - Both are registered alongside keys_level and are never high together for the same key.
- **Auto-repeat (REPEAT_EN=1), per key.** 2-state FSM: WAIT_FIRST, REPEATING. rcnt width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
  - On an accepted press: state <= WAIT_FIRST, rcnt <= 0.
  - While keys_level=1, rcnt increments each cycle.
  - In WAIT_FIRST, when rcnt reaches REPEAT_DELAY-1: pulse keys_press, rcnt <= 0, state <= REPEATING.
  - In REPEATING, when rcnt reaches REPEAT_PERIOD-1: pulse keys_press, rcnt <= 0.
  - Release: state <= WAIT_FIRST, rcnt <= 0, no repeat strobe that cycle.
  - A repeat strobe never coincides with the release strobe.
- **Auto-repeat disabled (REPEAT_EN=0).** The repeat logic is absent; keys_press fires once per accepted press.
- **Simultaneous events.** Keys never interact; any subset may press or release in the same cycle, each with its own strobes.
- **Reset mid-operation** (counting, held, or repeating): all counters go to 0, FSMs to WAIT_FIRST, outputs to 0, synchronisers to the inactive level. A key still held after reset deasserts is re-accepted after the normal latency and produces a fresh press strobe.
- **Counter wrap.** Counters saturate by construction (always cleared at terminal count); there is no free-running wrap.

Test Plan (bench params: N_KEYS=4, ACTIVE_LOW=1, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
1. Reset with keys_raw=4'b1111, release, idle 20 cycles -> keys_level=0, keys_press=0, keys_release=0 throughout.
2. keys_raw[0] driven 0 and held -> keys_level[0] rises 5 cycles after the first sampling edge; keys_press[0] high exactly 1 cycle; other bits stay 0.
3. keys_raw[1] pulses 0 for 3 cycles, then 1, repeated 5 times -> keys_level[1] never rises, no strobes.
4. keys_raw[2] held 0 for 40 cycles after acceptance -> keys_press[2] pulses at acceptance, then +10, +15, +20, +25, +30, +35 cycles; on release, keys_release[2] pulses once, 5 cycles after the raw edge, with no press pulse in that cycle.
5. keys_raw[0] and keys_raw[3] go to 0 on the same edge, then keys_raw[0] returns to 1 after 12 cycles -> both press strobes fire in the same cycle; key 0 releases independently; key 3 continues its repeat schedule unaffected.
6. Assert reset for 2 cycles while key 2 is repeating and still held -> outputs 0 immediately and asynchronously; after deassert, keys_level[2] re-rises after 5 cycles with a fresh press strobe, and the first repeat comes 10 cycles later.
